// File: rtl/gpu_mem_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ per-thread load/store requesters onto one
// data-memory port, one transaction at a time. Define GPU_MEM_ARB_PERF_EN for perf counters.
//
// state | meaning
// IDLE  | no transaction; grant and capture the request in the same cycle
// ISSUE | presenting the captured request downstream until mem_req_rdy
// WAIT  | waiting for load data or the store acknowledge
// RESP  | returning the response to the owning requester until it is taken
module gpu_mem_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_val,
  output logic [NUM_REQ-1:0]                req_rdy,
  input  logic [NUM_REQ-1:0]                req_we,
  input  logic [NUM_REQ*MEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*MEM_DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                resp_val,
  input  logic [NUM_REQ-1:0]                resp_rdy,
  output logic [MEM_DATA_WIDTH-1:0]         resp_data,
  output logic                              mem_req_val,
  input  logic                              mem_req_rdy,
  output logic                              mem_req_we,
  output logic [MEM_ADDR_WIDTH-1:0]         mem_req_addr,
  output logic [MEM_DATA_WIDTH-1:0]         mem_req_wdata,
  input  logic                              mem_resp_val,
  output logic                              mem_resp_rdy,
  input  logic [MEM_DATA_WIDTH-1:0]         mem_resp_data
`ifdef GPU_MEM_ARB_PERF_EN
  ,
  output logic [31:0]                       perf_busy_cycles,
  output logic [31:0]                       perf_grants
`endif
);

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]          rr_ptr, owner, grant, rr_nxt;
  logic                      grant_vld;
  logic                      accept;
  logic                      we_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [MEM_DATA_WIDTH-1:0] wdata_q;
  logic [MEM_DATA_WIDTH-1:0] rdata_q;

  logic [MEM_ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [MEM_DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
      wdata_arr[i] = req_wdata[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    end
  end

  // Scan from rr_ptr upward with an explicit wrap so non-power-of-two NUM_REQ works.
  always_comb begin
    int               scan;
    logic [IDX_W-1:0] scan_idx;
    scan      = 0;
    scan_idx  = '0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_REQ) begin
        scan = scan - NUM_REQ;
      end
      scan_idx = IDX_W'(scan);
      if (!grant_vld && req_val[scan_idx]) begin
        grant     = scan_idx;
        grant_vld = 1'b1;
      end
    end
  end

  assign rr_nxt = (int'(grant) == NUM_REQ - 1) ? '0 : grant + IDX_W'(1);
  assign accept = (state == S_IDLE) && grant_vld;

  always_comb begin
    state_nxt    = state;
    req_rdy      = '0;
    resp_val     = '0;
    resp_data    = '0;
    mem_req_val  = 1'b0;
    mem_resp_rdy = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_vld) begin
          // Masked by reset so every output reads 0 while reset is held.
          req_rdy[grant] = reset;
          state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_req_val = 1'b1;
        if (mem_req_rdy) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_resp_rdy = 1'b1;
        if (mem_resp_val) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        resp_val[owner] = 1'b1;
        resp_data       = rdata_q;
        if (resp_rdy[owner]) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we[grant];
        addr_q  <= addr_arr[grant];
        wdata_q <= wdata_arr[grant];
        owner   <= grant;
        rr_ptr  <= rr_nxt;
      end
      // Store acks carry no data; returning 0 keeps resp_data deterministic.
      if (state == S_WAIT && mem_resp_val) begin
        rdata_q <= we_q ? '0 : mem_resp_data;
      end
    end
  end

`ifdef GPU_MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_busy_cycles <= '0;
      perf_grants      <= '0;
    end else begin
      if (state != S_IDLE && perf_busy_cycles != 32'hFFFF_FFFF) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
      if (accept && perf_grants != 32'hFFFF_FFFF) begin
        perf_grants <= perf_grants + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Scoreboard bench for gpu_mem_arbiter: expected memory requests and responses are queued
// as stimulus is driven and popped as the arbiter produces them.
module tb_gpu_mem_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic [NR-1:0] req_val, req_rdy, req_we, resp_val, resp_rdy;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0] resp_data;
  logic          mem_req_val, mem_req_rdy, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_resp_val, mem_resp_rdy;
  logic [DW-1:0] mem_resp_data;
`ifdef GPU_MEM_ARB_PERF_EN
  logic [31:0]   perf_busy_cycles, perf_grants;
`endif

  int   checks    = 0;
  int   failures  = 0;
  int   stall_cfg = 0;
  logic spurious  = 1'b0;

  typedef struct { int ch; logic [DW-1:0] data; } resp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
  resp_t exp_resp_q[$];
  req_t  exp_req_q[$];

  gpu_mem_arbiter #(.NUM_REQ(NR), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_data(mem_resp_data)
`ifdef GPU_MEM_ARB_PERF_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_grants(perf_grants)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a ^ 8'h5C, ~a};
  endfunction

  // Downstream memory: optional request stall, response one cycle after acceptance,
  // optional junk mem_resp_val while the arbiter is not ready for it.
  initial begin
    int issue_cnt;
    issue_cnt     = 0;
    mem_req_rdy   = 1'b0;
    mem_resp_val  = 1'b0;
    mem_resp_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        issue_cnt    = 0;
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        mem_resp_data = '0;
      end else begin
        if (mem_req_val) begin
          mem_req_rdy = (issue_cnt >= stall_cfg);
          issue_cnt++;
        end else begin
          issue_cnt   = 0;
          mem_req_rdy = 1'b1;
        end
        if (mem_resp_rdy) begin
          mem_resp_val  = 1'b1;
          mem_resp_data = mem_req_we ? 16'hDEAD : mem_word(mem_req_addr);
        end else begin
          mem_resp_val  = spurious;
          mem_resp_data = 16'h5A5A;
        end
      end
    end
  end

  task automatic set_req(input int ch, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    req_val[ch]            = 1'b1;
    req_we[ch]             = we;
    req_addr[ch*AW +: AW]  = addr;
    req_wdata[ch*DW +: DW] = wdata;
  endtask

  task automatic push_exp(input int ch, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    exp_req_q.push_back('{we: we, addr: addr, wdata: wdata});
    exp_resp_q.push_back('{ch: ch, data: (we ? 16'h0000 : mem_word(addr))});
  endtask

  function automatic resp_t pop_resp();
    if (exp_resp_q.size() == 0) return '{ch: 99, data: 'x};
    return exp_resp_q.pop_front();
  endfunction

  function automatic req_t pop_req();
    if (exp_req_q.size() == 0) return '{we: 'x, addr: 'x, wdata: 'x};
    return exp_req_q.pop_front();
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    req_val = '1; req_we = '1; req_addr = '1; req_wdata = '1; resp_rdy = '1;
    repeat (2) @(negedge clk);
    checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL rst_req_rdy got=%b exp=0000", req_rdy); end
    checks++; if (resp_val !== 4'b0000) begin failures++; $display("FAIL rst_resp_val got=%b exp=0000", resp_val); end
    checks++; if (resp_data !== 16'h0) begin failures++; $display("FAIL rst_resp_data got=%h exp=0000", resp_data); end
    checks++; if (mem_req_val !== 1'b0) begin failures++; $display("FAIL rst_mem_req_val got=%b exp=0", mem_req_val); end
    checks++; if (mem_req_we !== 1'b0) begin failures++; $display("FAIL rst_mem_req_we got=%b exp=0", mem_req_we); end
    checks++; if (mem_req_addr !== 8'h0) begin failures++; $display("FAIL rst_mem_req_addr got=%h exp=00", mem_req_addr); end
    checks++; if (mem_req_wdata !== 16'h0) begin failures++; $display("FAIL rst_mem_req_wdata got=%h exp=0000", mem_req_wdata); end
    checks++; if (mem_resp_rdy !== 1'b0) begin failures++; $display("FAIL rst_mem_resp_rdy got=%b exp=0", mem_resp_rdy); end
    req_val = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_load();
    resp_t r;
    req_t  q;
    set_req(2, 1'b0, 8'h10, 16'h0);
    push_exp(2, 1'b0, 8'h10, 16'h0);
    #1;
    checks++; if (req_rdy !== 4'b0100) begin failures++; $display("FAIL load_grant got=%b exp=0100", req_rdy); end
    @(negedge clk);
    req_val = '0;
    q = pop_req();
    checks++; if (mem_req_val !== 1'b1 || mem_req_addr !== q.addr || mem_req_we !== q.we) begin
      failures++; $display("FAIL load_issue val=%b addr=%h we=%b exp 1/%h/%b", mem_req_val, mem_req_addr, mem_req_we, q.addr, q.we);
    end
    @(negedge clk);
    checks++; if (mem_resp_rdy !== 1'b1 || resp_val !== 4'b0000) begin
      failures++; $display("FAIL load_wait mem_resp_rdy=%b resp_val=%b exp 1/0000", mem_resp_rdy, resp_val);
    end
    @(negedge clk);
    r = pop_resp();
    checks++; if (resp_val !== 4'(1 << r.ch) || resp_data !== r.data) begin
      failures++; $display("FAIL load_resp resp_val=%b data=%h exp %b/%h", resp_val, resp_data, 4'(1 << r.ch), r.data);
    end
    @(negedge clk);
    checks++; if (resp_val !== 4'b0000) begin failures++; $display("FAIL load_done resp_val=%b exp=0000", resp_val); end
    // rr_ptr should now point at ch3, so ch3 wins over ch0
    set_req(0, 1'b0, 8'h20, 16'h0);
    set_req(3, 1'b0, 8'h30, 16'h0);
    push_exp(3, 1'b0, 8'h30, 16'h0);
    #1;
    checks++; if (req_rdy !== 4'b1000) begin failures++; $display("FAIL rr_after_load got=%b exp=1000", req_rdy); end
    @(negedge clk);
    req_val = '0;
    q = pop_req();
    checks++; if (mem_req_addr !== q.addr) begin failures++; $display("FAIL rr_after_load_addr got=%h exp=%h", mem_req_addr, q.addr); end
    repeat (2) @(negedge clk);
    r = pop_resp();
    checks++; if (resp_val !== 4'(1 << r.ch) || resp_data !== r.data) begin
      failures++; $display("FAIL rr_after_load_resp resp_val=%b data=%h exp %b/%h", resp_val, resp_data, 4'(1 << r.ch), r.data);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int    exp_grant[$];
    int    n_grant, n_resp, ch;
    bit    drop;
    resp_t r;
    req_t  q;
    n_grant = 0; n_resp = 0; drop = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8'(i), 16'h0);
    for (int k = 0; k < 5; k++) begin
      exp_grant.push_back(k % NR);
      push_exp(k % NR, 1'b0, 8'(k % NR), 16'h0);
    end
    for (int cyc = 0; cyc < 100 && n_resp < 5; cyc++) begin
      #1;
      if (req_rdy != 4'b0000) begin
        ch = (exp_grant.size() != 0) ? exp_grant.pop_front() : 99;
        checks++; if (req_rdy !== 4'(1 << ch)) begin failures++; $display("FAIL rr_grant got=%b exp=%b", req_rdy, 4'(1 << ch)); end
        n_grant++;
        if (n_grant == 5) drop = 1'b1;
      end
      if (mem_req_val && mem_req_rdy) begin
        q = pop_req();
        checks++; if (mem_req_addr !== q.addr || mem_req_we !== q.we) begin
          failures++; $display("FAIL rr_mem_req addr=%h we=%b exp %h/%b", mem_req_addr, mem_req_we, q.addr, q.we);
        end
      end
      if ((resp_val & resp_rdy) != 4'b0000) begin
        r = pop_resp();
        checks++; if (resp_val !== 4'(1 << r.ch) || resp_data !== r.data) begin
          failures++; $display("FAIL rr_resp resp_val=%b data=%h exp %b/%h", resp_val, resp_data, 4'(1 << r.ch), r.data);
        end
        n_resp++;
      end
      @(negedge clk);
      if (drop) req_val = '0;
    end
    checks++; if (n_resp != 5) begin failures++; $display("FAIL rr_timeout responses=%0d exp=5", n_resp); end
    req_val = '0;
    @(negedge clk);
  endtask

  task automatic test_store();
    resp_t r;
    req_t  q;
    spurious = 1'b1;
    set_req(0, 1'b1, 8'h22, 16'h1234);
    push_exp(0, 1'b1, 8'h22, 16'h1234);
    #1;
    checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL store_grant got=%b exp=0001", req_rdy); end
    @(negedge clk);
    req_val = '0;
    q = pop_req();
    checks++; if (mem_req_val !== 1'b1 || mem_req_we !== q.we || mem_req_addr !== q.addr || mem_req_wdata !== q.wdata) begin
      failures++; $display("FAIL store_issue val=%b we=%b addr=%h wdata=%h exp 1/%b/%h/%h",
                           mem_req_val, mem_req_we, mem_req_addr, mem_req_wdata, q.we, q.addr, q.wdata);
    end
    @(negedge clk);
    checks++; if (mem_resp_rdy !== 1'b1) begin failures++; $display("FAIL store_wait mem_resp_rdy=%b exp=1", mem_resp_rdy); end
    @(negedge clk);
    r = pop_resp();
    checks++; if (resp_val !== 4'(1 << r.ch) || resp_data !== r.data) begin
      failures++; $display("FAIL store_ack resp_val=%b data=%h exp %b/%h", resp_val, resp_data, 4'(1 << r.ch), r.data);
    end
    @(negedge clk);
    spurious = 1'b0;
    checks++; if (resp_val !== 4'b0000 || mem_req_val !== 1'b0) begin
      failures++; $display("FAIL store_done resp_val=%b mem_req_val=%b exp 0000/0", resp_val, mem_req_val);
    end
  endtask

  task automatic test_backpressure();
    resp_t r;
    req_t  q;
    stall_cfg = 5;
    resp_rdy  = 4'b1101;
    set_req(1, 1'b0, 8'h35, 16'h0);
    push_exp(1, 1'b0, 8'h35, 16'h0);
    #1;
    checks++; if (req_rdy !== 4'b0010) begin failures++; $display("FAIL bp_grant got=%b exp=0010", req_rdy); end
    @(negedge clk);
    req_val = '0;
    set_req(2, 1'b0, 8'h44, 16'h0);
    push_exp(2, 1'b0, 8'h44, 16'h0);
    q = pop_req();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (mem_req_val !== 1'b1 || mem_req_addr !== q.addr || mem_req_we !== q.we || req_rdy !== 4'b0000) begin
        failures++; $display("FAIL bp_issue cyc=%0d val=%b addr=%h we=%b req_rdy=%b exp 1/%h/%b/0000",
                             c, mem_req_val, mem_req_addr, mem_req_we, req_rdy, q.addr, q.we);
      end
    end
    @(negedge clk);
    checks++; if (mem_req_val !== 1'b0 || mem_resp_rdy !== 1'b1 || req_rdy !== 4'b0000) begin
      failures++; $display("FAIL bp_wait val=%b mem_resp_rdy=%b req_rdy=%b exp 0/1/0000", mem_req_val, mem_resp_rdy, req_rdy);
    end
    @(negedge clk);
    r = pop_resp();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (resp_val !== 4'(1 << r.ch) || resp_data !== r.data || req_rdy !== 4'b0000) begin
        failures++; $display("FAIL bp_resp_hold cyc=%0d resp_val=%b data=%h req_rdy=%b exp %b/%h/0000",
                             c, resp_val, resp_data, req_rdy, 4'(1 << r.ch), r.data);
      end
    end
    resp_rdy = '1;
    @(negedge clk);
    stall_cfg = 0;
    checks++; if (req_rdy !== 4'b0100) begin failures++; $display("FAIL bp_next_grant got=%b exp=0100", req_rdy); end
    @(negedge clk);
    req_val = '0;
    q = pop_req();
    checks++; if (mem_req_addr !== q.addr) begin failures++; $display("FAIL bp_next_addr got=%h exp=%h", mem_req_addr, q.addr); end
    repeat (2) @(negedge clk);
    r = pop_resp();
    checks++; if (resp_val !== 4'(1 << r.ch) || resp_data !== r.data) begin
      failures++; $display("FAIL bp_next_resp resp_val=%b data=%h exp %b/%h", resp_val, resp_data, 4'(1 << r.ch), r.data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    resp_t r;
    req_t  q;
    set_req(1, 1'b0, 8'h07, 16'h0);
    #1;
    checks++; if (req_rdy !== 4'b0010) begin failures++; $display("FAIL mid_grant got=%b exp=0010", req_rdy); end
    @(negedge clk);
    req_val = '0;
    @(negedge clk);
    checks++; if (mem_resp_rdy !== 1'b1) begin failures++; $display("FAIL mid_in_wait mem_resp_rdy=%b exp=1", mem_resp_rdy); end
    set_req(3, 1'b0, 8'h3C, 16'h0);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (req_rdy !== 4'b0000 || resp_val !== 4'b0000 || resp_data !== 16'h0) begin
      failures++; $display("FAIL mid_rst_resp req_rdy=%b resp_val=%b data=%h exp 0000/0000/0000", req_rdy, resp_val, resp_data);
    end
    checks++; if (mem_req_val !== 1'b0 || mem_resp_rdy !== 1'b0 || mem_req_addr !== 8'h0) begin
      failures++; $display("FAIL mid_rst_mem val=%b resp_rdy=%b addr=%h exp 0/0/00", mem_req_val, mem_resp_rdy, mem_req_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push_exp(3, 1'b0, 8'h3C, 16'h0);
    #1;
    checks++; if (req_rdy !== 4'b1000) begin failures++; $display("FAIL mid_post_grant got=%b exp=1000", req_rdy); end
    @(negedge clk);
    req_val = '0;
    q = pop_req();
    checks++; if (mem_req_addr !== q.addr) begin failures++; $display("FAIL mid_post_addr got=%h exp=%h", mem_req_addr, q.addr); end
    repeat (2) @(negedge clk);
    r = pop_resp();
    checks++; if (resp_val !== 4'(1 << r.ch) || resp_data !== r.data) begin
      failures++; $display("FAIL mid_post_resp resp_val=%b data=%h exp %b/%h", resp_val, resp_data, 4'(1 << r.ch), r.data);
    end
    @(negedge clk);
    // rr_ptr wrapped to 0: ch0 must beat ch1
    set_req(0, 1'b0, 8'h40, 16'h0);
    set_req(1, 1'b0, 8'h41, 16'h0);
    push_exp(0, 1'b0, 8'h40, 16'h0);
    #1;
    checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL mid_wrap_grant got=%b exp=0001", req_rdy); end
    @(negedge clk);
    req_val = '0;
    q = pop_req();
    checks++; if (mem_req_addr !== q.addr) begin failures++; $display("FAIL mid_wrap_addr got=%h exp=%h", mem_req_addr, q.addr); end
    repeat (2) @(negedge clk);
    r = pop_resp();
    checks++; if (resp_val !== 4'(1 << r.ch) || resp_data !== r.data) begin
      failures++; $display("FAIL mid_wrap_resp resp_val=%b data=%h exp %b/%h", resp_val, resp_data, 4'(1 << r.ch), r.data);
    end
    @(negedge clk);
  endtask

`ifdef GPU_MEM_ARB_PERF_EN
  task automatic test_perf();
    resp_t r;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (perf_grants !== 32'd0 || perf_busy_cycles !== 32'd0) begin
      failures++; $display("FAIL perf_clear grants=%0d busy=%0d exp 0/0", perf_grants, perf_busy_cycles);
    end
    for (int n = 0; n < 2; n++) begin
      set_req(n, 1'b0, 8'(8'h50 + n), 16'h0);
      push_exp(n, 1'b0, 8'(8'h50 + n), 16'h0);
      @(negedge clk);
      req_val = '0;
      void'(pop_req());
      repeat (2) @(negedge clk);
      r = pop_resp();
      checks++; if (resp_val !== 4'(1 << r.ch) || resp_data !== r.data) begin
        failures++; $display("FAIL perf_resp resp_val=%b data=%h exp %b/%h", resp_val, resp_data, 4'(1 << r.ch), r.data);
      end
      @(negedge clk);
    end
    checks++; if (perf_grants !== 32'd2 || perf_busy_cycles !== 32'd6) begin
      failures++; $display("FAIL perf_counts grants=%0d busy=%0d exp 2/6", perf_grants, perf_busy_cycles);
    end
  endtask
`endif

  initial begin
    reset     = 1'b0;
    req_val   = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    resp_rdy  = '1;
    test_reset();
    test_single_load();
    test_round_robin();
    test_store();
    test_backpressure();
    test_reset_mid_op();
`ifdef GPU_MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpu_mem_arbiter.md
Name: gpu_mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one global data-memory port among NUM_REQ per-thread load/store requesters. Sits between the core's per-thread LSUs and the data memory controller.
- Carries at most one transaction at a time. Each transaction follows the fixed sequence: accept, issue, await response, return to requester.

Parameters:
- NUM_REQ, 4, number of requester channels (>=2).
- MEM_ADDR_WIDTH, 8, address width.
- MEM_DATA_WIDTH, 16, data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset. The port is named reset and is active-low: 0 = in reset.
- req_val  in  NUM_REQ  per-channel request valid.
- req_rdy  out  NUM_REQ  per-channel request accepted (one-hot or zero).
- req_we  in  NUM_REQ  per-channel write enable; 1 = store, 0 = load.
- req_addr  in  NUM_REQ*MEM_ADDR_WIDTH  packed; channel i occupies [i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH].
- req_wdata  in  NUM_REQ*MEM_DATA_WIDTH  packed store data.
- resp_val  out  NUM_REQ  per-channel response valid (one-hot or zero).
- resp_rdy  in  NUM_REQ  per-channel response ready.
- resp_data  out  MEM_DATA_WIDTH  load data, shared by all channels; qualified by resp_val.
- mem_req_val  out  1  downstream request valid.
- mem_req_rdy  in  1  downstream request ready.
- mem_req_we  out  1  downstream write enable.
- mem_req_addr  out  MEM_ADDR_WIDTH  downstream address.
- mem_req_wdata  out  MEM_DATA_WIDTH  downstream store data.
- mem_resp_val  in  1  downstream response valid; for stores this is the write acknowledge.
- mem_resp_rdy  out  1  downstream response ready.
- mem_resp_data  in  MEM_DATA_WIDTH  downstream load data.

Behaviour:
- FSM states and transitions:
  - IDLE -> ISSUE when any req_val is high.
  - ISSUE -> WAIT when mem_req_rdy is high.
  - WAIT -> RESP when mem_resp_val is high.
  - RESP -> IDLE when resp_rdy[owner] is high.
- Reset (reset=0, asynchronous):
  - State = IDLE, rr_ptr = 0, owner = 0, latched addr/wdata/we/rdata = 0.
  - All outputs 0.
  - Takes effect mid-transaction with no completion. The downstream memory is reset on the same reset, so no stale response is expected.
- IDLE:
  - Grant goes to the first i with req_val[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_rdy[grant] is asserted combinationally in the same cycle; all other req_rdy bits are 0.
  - On that edge, latch we/addr/wdata of the granted channel, set owner = grant, set rr_ptr = (grant+1) mod NUM_REQ.
  - With no req_val, req_rdy = 0 and rr_ptr is unchanged.
- ISSUE:
  - mem_req_val = 1, driving the latched we/addr/wdata; fields are stable while waiting.
  - Advance on mem_req_rdy.
  - req_rdy = 0 for all channels.
- WAIT:
  - mem_resp_rdy = 1.
  - On mem_resp_val, latch mem_resp_data (loads); for stores the latch value is don't-care, and resp_data is driven as 0.
- RESP:
  - resp_val[owner] = 1 and resp_data = latched data.
  - Hold until resp_rdy[owner].
  - Store responses are acks.
- Minimum latency, with downstream ready and responding in 1 cycle, accept to resp_val: 3 cycles (accept@0, ISSUE@1, WAIT@2, RESP@3).
- Back-to-back throughput: one transaction per 4 cycles minimum.
- Fairness:
  - With all channels requesting continuously, grants rotate 0,1,2,3,0,...
  - A channel waits at most NUM_REQ-1 transactions.
- A requester must hold req_val and its fields until req_rdy. A requester may drop req_val before grant; no grant then occurs for it.
- mem_resp_val received outside WAIT is ignored, because mem_resp_rdy = 0 outside WAIT.
- Index width is max(1, $clog2(NUM_REQ)). rr_ptr wrap uses a modulo compare, not a power-of-two mask, so non-power-of-two NUM_REQ works.

Optional Feature:
- Macro: GPU_MEM_ARB_PERF_EN.
- Defined: adds outputs perf_busy_cycles [31:0] and perf_grants [31:0].
  - perf_busy_cycles increments every cycle state != IDLE.
  - perf_grants increments on every IDLE grant.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: neither port nor any counter logic exists; behaviour is otherwise identical.

Test Plan:
- Single load: ch2 load addr 0x10; memory rdy immediately, responds 0xBEEF one cycle later → mem_req_addr=0x10 with we=0 at cycle 1; resp_val=4'b0100 with resp_data=0xBEEF at cycle 3; rr_ptr=3.
- Store ack: ch0 store addr 0x22 data 0x1234 → mem_req_we=1, addr 0x22, wdata 0x1234; after ack, resp_val[0]=1 with resp_data=0.
- Round-robin: all 4 channels hold req_val with distinct addresses 0x00..0x03 → grant order 0,1,2,3,0; mem_req_addr sequence matches.
- Backpressure: mem_req_rdy low 5 cycles, then resp_rdy[1] low 3 cycles → mem_req fields stable throughout, resp_val/resp_data held stable, no new grant until RESP → IDLE.
- Reset mid-op: reset=0 asserted during WAIT → all outputs 0 immediately (async); after release, a ch3 request is granted first because rr_ptr=0 and it is the only requester, then rr_ptr=0 (wrap).
- GPU_MEM_ARB_PERF_EN: 2 single-cycle-response loads → perf_grants=2, perf_busy_cycles=6.
